// File: rtl/pipe_stage_skid_pkg.sv
// Shared defines for the ID/EX skid stage: occupancy-state encoding,
// pipeline hold levels and the NOP instruction pattern.
package pipe_stage_skid_pkg;

  // Occupancy states; the encoding doubles as the occ_o count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Pipeline hold levels; a stage is held when the request is at or above its level.
  localparam int unsigned HOLD_NONE = 0;
  localparam int unsigned HOLD_PC   = 1;
  localparam int unsigned HOLD_IF   = 2;
  localparam int unsigned HOLD_ID   = 3;

  // addi x0, x0, 0 -- the canonical RISC-V NOP.
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_skid_gen_en_dff.sv
// Enabled DW-bit register with asynchronous reset to DEF_VAL.
module gen_en_dff #(
  parameter int unsigned    DW      = 288,
  parameter logic [DW-1:0]  DEF_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] data_q;

  // Load d_i when enabled; reset returns the register to DEF_VAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= DEF_VAL;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage (head + skid) with hold and flush.
//
// Handshake: a beat moves on a port only in a cycle where valid and ready
// are both 1 at the rising edge. in_ready_o depends only on registered state,
// hold_flag_i and flush_i (never on out_ready_i or in_valid_i), and
// out_valid_o is never withdrawn by the stage except by hold, flush or reset;
// out_data_o stays stable while out_valid_o=1 and out_ready_i=0.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned   DW         = 288,
  parameter logic [DW-1:0] DEF_VAL    = '0,
  parameter int unsigned   HFW        = 3,
  parameter int unsigned   HOLD_LEVEL = HOLD_ID
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid_i,
  input  logic [DW-1:0]  in_data_i,
  output logic           in_ready_o,
  output logic           out_valid_o,
  output logic [DW-1:0]  out_data_o,
  input  logic           out_ready_i,
  input  logic [HFW-1:0] hold_flag_i,
  input  logic           flush_i,
  output logic [1:0]     occ_o
);

  logic [1:0]    state_q, state_d;
  logic          head_en, skid_en;
  logic [DW-1:0] head_d, skid_d;
  logic [DW-1:0] head_q, skid_q;
  logic          hold_en, in_fire, out_fire;

  assign hold_en     = (32'(hold_flag_i) >= HOLD_LEVEL);
  assign in_ready_o  = (state_q != ST_FULL)  & ~hold_en & ~flush_i;
  assign out_valid_o = (state_q != ST_EMPTY) & ~hold_en & ~flush_i;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;
  assign out_data_o  = (state_q != ST_EMPTY) ? head_q : DEF_VAL;
  assign occ_o       = state_q;

  // Next-state and entry-load decode; flush overrides everything, hold
  // suppresses both fires so the stage simply keeps its contents.
  always_comb begin
    state_d = state_q;
    head_en = 1'b0;
    head_d  = in_data_i;
    skid_en = 1'b0;
    skid_d  = in_data_i;
    if (flush_i) begin
      state_d = ST_EMPTY;
      head_en = 1'b1;
      head_d  = DEF_VAL;
      skid_en = 1'b1;
      skid_d  = DEF_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            head_en = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            head_en = 1'b1;
          end else if (in_fire) begin
            skid_en = 1'b1;
            state_d = ST_FULL;
          end else if (out_fire) begin
            head_en = 1'b1;
            head_d  = DEF_VAL;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            head_en = 1'b1;
            head_d  = skid_q;
            skid_en = 1'b1;
            skid_d  = DEF_VAL;
            state_d = ST_ONE;
          end
        end
        default: begin
          // Unreachable encoding: recover to empty.
          state_d = ST_EMPTY;
          head_en = 1'b1;
          head_d  = DEF_VAL;
          skid_en = 1'b1;
          skid_d  = DEF_VAL;
        end
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  gen_en_dff #(.DW(DW), .DEF_VAL(DEF_VAL)) u_head (
    .clk  (clk),
    .rst  (rst),
    .en_i (head_en),
    .d_i  (head_d),
    .q_o  (head_q)
  );

  gen_en_dff #(.DW(DW), .DEF_VAL(DEF_VAL)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .en_i (skid_en),
    .d_i  (skid_d),
    .q_o  (skid_q)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: driver issues beats and pushes the
// expected output order; an independent monitor pops on each output fire.
module tb_pipe_stage_skid;

  localparam int unsigned   DW  = 32;
  localparam logic [DW-1:0] DEF = 32'h0000_0013;
  localparam int unsigned   HL  = 3;

  logic          clk;
  logic          rst;
  logic          in_valid_i;
  logic [DW-1:0] in_data_i;
  logic          in_ready_o;
  logic          out_valid_o;
  logic [DW-1:0] out_data_o;
  logic          out_ready_i;
  logic [2:0]    hold_flag_i;
  logic          flush_i;
  logic [1:0]    occ_o;

  logic [DW-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  pipe_stage_skid #(.DW(DW), .DEF_VAL(DEF), .HFW(3), .HOLD_LEVEL(HL)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i),
    .hold_flag_i (hold_flag_i),
    .flush_i     (flush_i),
    .occ_o       (occ_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; status checks are taken at the falling edge,
  // i.e. the values the DUT presents for the coming rising edge.
  task automatic cyc(input string tag, input logic v, input logic [DW-1:0] d,
                     input logic ordy, input logic [2:0] hf, input logic fl,
                     input logic e_rdy, input logic e_vld, input logic [1:0] e_occ,
                     input logic cd, input logic [DW-1:0] ed);
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = ordy;
    hold_flag_i = hf;
    flush_i     = fl;
    @(negedge clk);
    check({tag, ".in_ready"},  DW'(in_ready_o),  DW'(e_rdy));
    check({tag, ".out_valid"}, DW'(out_valid_o), DW'(e_vld));
    check({tag, ".occ"},       DW'(occ_o),       DW'(e_occ));
    if (cd) check({tag, ".data"}, out_data_o, ed);
    if (fl) exp_q.delete();
    else if (v && e_rdy) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output fire must deliver the oldest outstanding beat.
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL mon.unexpected: got %h expected none at %0t", out_data_o, $time);
      end else begin
        check("mon.data", out_data_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;
    hold_flag_i = 3'd0;
    flush_i     = 1'b0;
    #2;
    check("rst.occ",       DW'(occ_o),       DW'(2'd0));
    check("rst.out_valid", DW'(out_valid_o), DW'(1'b0));
    check("rst.data",      out_data_o,       DEF);
    @(posedge clk); #1;
    rst = 1'b0;

    // Streaming 0x11..0x14 with downstream ready.
    cyc("s0", 1, 32'h11, 1, 0, 0, 1, 0, 0, 1, DEF);
    cyc("s1", 1, 32'h12, 1, 0, 0, 1, 1, 1, 1, 32'h11);
    cyc("s2", 1, 32'h13, 1, 0, 0, 1, 1, 1, 1, 32'h12);
    cyc("s3", 1, 32'h14, 1, 0, 0, 1, 1, 1, 1, 32'h13);
    cyc("s4", 0, 32'h0,  1, 0, 0, 1, 1, 1, 1, 32'h14);
    cyc("s5", 0, 32'h0,  1, 0, 0, 1, 0, 0, 1, DEF);

    // Backpressure fills the skid, third beat waits.
    cyc("b0", 1, 32'hA1, 0, 0, 0, 1, 0, 0, 0, '0);
    cyc("b1", 1, 32'hA2, 0, 0, 0, 1, 1, 1, 1, 32'hA1);
    cyc("b2", 1, 32'hA3, 0, 0, 0, 0, 1, 2, 1, 32'hA1);
    cyc("b3", 1, 32'hA3, 1, 0, 0, 0, 1, 2, 1, 32'hA1);
    cyc("b4", 1, 32'hA3, 1, 0, 0, 1, 1, 1, 1, 32'hA2);
    cyc("b5", 0, 32'h0,  1, 0, 0, 1, 1, 1, 1, 32'hA3);
    cyc("b6", 0, 32'h0,  1, 0, 0, 1, 0, 0, 0, '0);

    // Hold at threshold freezes a full stage.
    cyc("h0", 1, 32'hB1, 0, 0, 0, 1, 0, 0, 0, '0);
    cyc("h1", 1, 32'hB2, 0, 0, 0, 1, 1, 1, 0, '0);
    for (int i = 0; i < 3; i++)
      cyc("h_hold", 1, 32'hBF, 1, 3'(HL), 0, 0, 0, 2, 1, 32'hB1);
    cyc("h2", 0, 32'h0, 1, 0, 0, 0, 1, 2, 1, 32'hB1);
    cyc("h3", 0, 32'h0, 1, 0, 0, 1, 1, 1, 1, 32'hB2);
    cyc("h4", 0, 32'h0, 1, 0, 0, 1, 0, 0, 0, '0);

    // Hold just below threshold has no effect.
    cyc("u0", 1, 32'h21, 1, 3'(HL - 1), 0, 1, 0, 0, 0, '0);
    cyc("u1", 1, 32'h22, 1, 3'(HL - 1), 0, 1, 1, 1, 1, 32'h21);
    cyc("u2", 1, 32'h23, 1, 3'(HL - 1), 0, 1, 1, 1, 1, 32'h22);
    cyc("u3", 1, 32'h24, 1, 3'(HL - 1), 0, 1, 1, 1, 1, 32'h23);
    cyc("u4", 0, 32'h0,  1, 3'(HL - 1), 0, 1, 1, 1, 1, 32'h24);
    cyc("u5", 0, 32'h0,  1, 0, 0, 1, 0, 0, 0, '0);

    // Flush of a full stage, with a beat offered (and hold) in the same cycle.
    cyc("f0", 1, 32'hC1, 0, 0, 0, 1, 0, 0, 0, '0);
    cyc("f1", 1, 32'hC2, 0, 0, 0, 1, 1, 1, 0, '0);
    cyc("f2", 1, 32'hC3, 1, 3'(HL), 1, 0, 0, 2, 0, '0);
    cyc("f3", 0, 32'h0,  1, 0, 0, 1, 0, 0, 1, DEF);

    // Asynchronous reset while full, mid-cycle.
    cyc("r0", 1, 32'hD1, 0, 0, 0, 1, 0, 0, 0, '0);
    cyc("r1", 1, 32'hD2, 0, 0, 0, 1, 1, 1, 0, '0);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check("ar.occ",       DW'(occ_o),       DW'(2'd0));
    check("ar.out_valid", DW'(out_valid_o), DW'(1'b0));
    check("ar.data",      out_data_o,       DEF);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("r2", 1, 32'hE1, 1, 0, 0, 1, 0, 0, 1, DEF);
    cyc("r3", 1, 32'hE2, 1, 0, 0, 1, 1, 1, 1, 32'hE1);
    cyc("r4", 0, 32'h0,  1, 0, 0, 1, 1, 1, 1, 32'hE2);
    cyc("r5", 0, 32'h0,  1, 0, 0, 1, 0, 0, 0, '0);

    check("end.exp_q_empty", DW'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
